// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the aFIFO write-port arbiter and its helpers:
// default word width, FSM state encoding and an index-width helper.
`ifndef bitLength
`define bitLength 8
`endif

package fifo_wr_arbiter_pkg;

  // Default word width, taken from the FIFO's bitLength define
  localparam int ARB_DATA_W = `bitLength;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Index width for n items, never narrower than one bit
  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority picker: scans req starting one above `last` and
// wrapping, reporting the first set bit. Purely combinational so it can be
// dropped into any scheduler that keeps its own last-winner register.
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  int            cand;
  logic [IW-1:0] cand_idx;

  // Walk the N candidates in rotated order; the first hit wins
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N; k++) begin
      cand     = (int'(last) + k) % N;
      cand_idx = IW'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of the shared aFIFO. Grants one
// producer at a time for a whole burst (up to MAX_BURST words), forwards its
// words straight to the FIFO write port and holds the grant across FULL.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_wr_en,
  output logic [DATA_W-1:0]           fifo_wr_data,
  output logic [clog2w(NUM_REQ)-1:0]  owner,
  output logic                        busy
);

  localparam int IW = clog2w(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_d;
  logic [IW-1:0] last_owner_q, last_owner_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          accept;
  logic          burst_end;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .last  (last_owner_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign busy = (state_q == ST_GRANT);

  // Control registers; reset sends requester 0 to the front of the rotation
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= ST_IDLE;
      owner        <= '0;
      last_owner_q <= IW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner        <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Next-state logic plus the combinational handshake and data mux.
  // FULL only blocks the write; it never ends a burst on its own.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    accept       = 1'b0;
    burst_end    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        accept           = req_valid[owner] & ~fifo_full;
        req_ready[owner] = accept;
        fifo_wr_en       = accept;
        fifo_wr_data     = req_data[owner*DATA_W +: DATA_W];
        if (accept) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
        // Last word, burst cap reached, or the requester walked away
        burst_end = (accept & (req_last[owner] | (beat_cnt_q == BW'(MAX_BURST - 1))))
                  | ~req_valid[owner];
        if (burst_end) begin
          state_d      = ST_IDLE;
          last_owner_d = owner;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a randomized run
// checked against a burst-level behavioural model and a FIFO scoreboard.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = 2;

  logic            Clk = 1'b0;
  logic            Rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic [IW-1:0]   owner;
  logic            busy;

  int total = 0;
  int bad   = 0;

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .owner        (owner),
    .busy         (busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Word tag: requester id in the top 2 bits, sequence number below
  function automatic logic [DW-1:0] word(input int id, input int seq);
    return {id[1:0], seq[5:0]};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic smp();
    @(negedge Clk);
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] w);
    req_data[i*DW +: DW] = w;
  endtask

  task automatic do_reset();
    Rst       = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    Rst       = 1'b0;
    req_valid = '1;
    req_last  = '1;
    for (int i = 0; i < N; i++) set_data(i, word(i, 5));
    @(posedge Clk);
    #1;
    total++;
    if ({busy, fifo_wr_en, req_ready, fifo_wr_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {busy, fifo_wr_en, req_ready, fifo_wr_data});
    end
    total++;
    if (owner !== 2'd0) begin
      bad++;
      $display("FAIL reset_owner got=%0d exp=0", owner);
    end
    Rst = 1'b1;
    smp();
    total++;
    if ({busy, fifo_wr_en} !== 2'b00) begin
      bad++;
      $display("FAIL reset_first_idle got=%b exp=00", {busy, fifo_wr_en});
    end
    tick();
    smp();
    total++;
    if ({busy, owner, fifo_wr_data} !== {1'b1, 2'd0, word(0, 5)}) begin
      bad++;
      $display("FAIL reset_first_grant got=%h exp=%h", {busy, owner, fifo_wr_data}, {1'b1, 2'd0, word(0, 5)});
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = '1;
    req_last  = '1;
    for (int i = 0; i < N; i++) set_data(i, word(i, 0));
    for (int k = 0; k < 5; k++) begin
      smp();
      total++;
      if ({busy, fifo_wr_en, req_ready} !== 6'b0) begin
        bad++;
        $display("FAIL rr_idle k=%0d got=%b exp=0", k, {busy, fifo_wr_en, req_ready});
      end
      tick();
      smp();
      total++;
      if ({busy, owner, fifo_wr_en, fifo_wr_data, req_ready} !==
          {1'b1, 2'(k % N), 1'b1, word(k % N, 0), 4'(1 << (k % N))}) begin
        bad++;
        $display("FAIL rr_grant k=%0d got=%h exp=%h", k, {busy, owner, fifo_wr_en, fifo_wr_data, req_ready},
                 {1'b1, 2'(k % N), 1'b1, word(k % N, 0), 4'(1 << (k % N))});
      end
      tick();
    end
  endtask

  task automatic test_max_burst();
    bit exp_en [9] = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
    int w = 1;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      req_valid = (w <= 6) ? 4'b0100 : 4'b0000;
      req_last  = (w == 6) ? 4'b0100 : 4'b0000;
      set_data(2, word(2, w));
      smp();
      total++;
      if ({busy, fifo_wr_en} !== {exp_en[c], exp_en[c]} ||
          (exp_en[c] && {owner, fifo_wr_data} !== {2'd2, word(2, w)})) begin
        bad++;
        $display("FAIL max_burst c=%0d got=%h exp=%h", c, {busy, fifo_wr_en, owner, fifo_wr_data},
                 {exp_en[c], exp_en[c], 2'd2, word(2, w)});
      end
      if (exp_en[c]) w++;
      tick();
    end
  endtask

  task automatic test_full_hold();
    bit full_s [11] = '{0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0};
    bit exp_en [11] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 1};
    bit exp_bz [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    int w = 1;
    logic [IW-1:0] eo;
    logic [DW-1:0] ed;
    do_reset();
    set_data(0, word(0, 0));
    for (int c = 0; c < 11; c++) begin
      req_valid = {2'b00, (w <= 4), (c >= 2)};
      req_last  = {2'b00, (w == 4), 1'b1};
      fifo_full = full_s[c];
      set_data(1, word(1, w));
      eo = (c < 10) ? 2'd1 : 2'd0;
      ed = (c < 10) ? word(1, w) : word(0, 0);
      smp();
      total++;
      if ({busy, fifo_wr_en} !== {exp_bz[c], exp_en[c]} ||
          (exp_bz[c] && owner !== eo) || (exp_en[c] && fifo_wr_data !== ed)) begin
        bad++;
        $display("FAIL full_hold c=%0d got=%h exp=%h", c, {busy, fifo_wr_en, owner, fifo_wr_data},
                 {exp_bz[c], exp_en[c], eo, ed});
      end
      if (exp_en[c] && c < 10) w++;
      tick();
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_dropout();
    bit exp_en [6] = '{0, 1, 1, 0, 0, 1};
    bit exp_bz [6] = '{0, 1, 1, 1, 0, 1};
    int w = 1;
    logic [IW-1:0] eo;
    logic [DW-1:0] ed;
    do_reset();
    set_data(0, word(0, 0));
    for (int c = 0; c < 6; c++) begin
      req_valid = {(c < 3), 2'b00, (c >= 1)};
      req_last  = 4'b0001;
      fifo_full = (c == 3);
      set_data(3, word(3, w));
      eo = (c < 4) ? 2'd3 : 2'd0;
      ed = (c < 4) ? word(3, w) : word(0, 0);
      smp();
      total++;
      if ({busy, fifo_wr_en} !== {exp_bz[c], exp_en[c]} ||
          (exp_bz[c] && owner !== eo) || (exp_en[c] && fifo_wr_data !== ed)) begin
        bad++;
        $display("FAIL dropout c=%0d got=%h exp=%h", c, {busy, fifo_wr_en, owner, fifo_wr_data},
                 {exp_bz[c], exp_en[c], eo, ed});
      end
      if (exp_en[c] && c < 4) w++;
      tick();
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    set_data(2, word(2, 1));
    tick();
    smp();
    total++;
    if ({busy, fifo_wr_en, fifo_wr_data} !== {2'b11, word(2, 1)}) begin
      bad++;
      $display("FAIL areset_word1 got=%h exp=%h", {busy, fifo_wr_en, fifo_wr_data}, {2'b11, word(2, 1)});
    end
    tick();
    set_data(2, word(2, 2));
    #2;
    total++;
    if (fifo_wr_en !== 1'b1) begin
      bad++;
      $display("FAIL areset_word2_pre got=%b exp=1", fifo_wr_en);
    end
    Rst = 1'b0;
    #1;
    total++;
    if ({busy, fifo_wr_en, req_ready, fifo_wr_data} !== '0) begin
      bad++;
      $display("FAIL areset_drop got=%h exp=0", {busy, fifo_wr_en, req_ready, fifo_wr_data});
    end
    @(posedge Clk);
    #1;
    Rst       = 1'b1;
    req_valid = '1;
    req_last  = '1;
    for (int i = 0; i < N; i++) set_data(i, word(i, 9));
    smp();
    total++;
    if ({busy, fifo_wr_en} !== 2'b00) begin
      bad++;
      $display("FAIL areset_idle got=%b exp=00", {busy, fifo_wr_en});
    end
    tick();
    smp();
    total++;
    if ({busy, owner, fifo_wr_en, fifo_wr_data} !== {1'b1, 2'd0, 1'b1, word(0, 9)}) begin
      bad++;
      $display("FAIL areset_regrant got=%h exp=%h", {busy, owner, fifo_wr_en, fifo_wr_data},
               {1'b1, 2'd0, 1'b1, word(0, 9)});
    end
    tick();
  endtask

  task automatic test_random();
    // Burst-level model: who holds the grant and how many words it has sent
    bit            m_busy = 0;
    int            m_owner = 0;
    int            m_last = N - 1;
    int            m_sent = 0;
    int            seq [N] = '{0, 0, 0, 0};
    logic [DW-1:0] fifo_q [$];
    int            nxt [N] = '{0, 0, 0, 0};
    bit            acc;
    logic [N-1:0]  e_ready;
    logic [DW-1:0] e_data;
    int            id;
    do_reset();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom % 10) < 7;
        req_last[i]  = ($urandom % 4) == 0;
        set_data(i, word(i, seq[i]));
      end
      fifo_full = ($urandom % 4) == 0;
      acc     = m_busy && req_valid[IW'(m_owner)] && !fifo_full;
      e_ready = acc ? 4'(1 << m_owner) : 4'b0;
      e_data  = m_busy ? word(m_owner, seq[m_owner]) : '0;
      smp();
      total++;
      if ({busy, fifo_wr_en, req_ready, fifo_wr_data} !== {m_busy, acc, e_ready, e_data} ||
          (m_busy && owner !== IW'(m_owner))) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h/%0d exp=%h/%0d", cyc, {busy, fifo_wr_en, req_ready, fifo_wr_data},
                 owner, {m_busy, acc, e_ready, e_data}, m_owner);
      end
      if (fifo_wr_en) begin
        total++;
        if (fifo_full) begin
          bad++;
          $display("FAIL write_while_full cyc=%0d got=1 exp=0", cyc);
        end
        fifo_q.push_back(fifo_wr_data);
      end
      if (m_busy) begin
        if (acc) begin
          seq[m_owner]++;
          m_sent++;
        end
        if ((acc && (req_last[IW'(m_owner)] || m_sent == MB)) || !req_valid[IW'(m_owner)]) begin
          m_busy = 0;
          m_last = m_owner;
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (!m_busy && req_valid[IW'((m_last + k) % N)]) begin
            m_busy  = 1;
            m_owner = (m_last + k) % N;
            m_sent  = 0;
          end
        end
      end
      tick();
    end
    fifo_full = 1'b0;
    req_valid = '0;
    // FIFO contents must replay each requester's words in order, none lost
    foreach (fifo_q[j]) begin
      id = int'(fifo_q[j][7:6]);
      total++;
      if (fifo_q[j][5:0] !== 6'(nxt[id])) begin
        bad++;
        $display("FAIL fifo_order j=%0d id=%0d got=%0d exp=%0d", j, id, fifo_q[j][5:0], nxt[id] % 64);
      end
      nxt[id]++;
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (nxt[i] != seq[i]) begin
        bad++;
        $display("FAIL fifo_count id=%0d got=%0d exp=%0d", i, nxt[i], seq[i]);
      end
    end
    total++;
    if (fifo_q.size() < 100) begin
      bad++;
      $display("FAIL fifo_volume got=%0d exp>=100", fifo_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_max_burst();
    test_full_hold();
    test_dropout();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the shared aFIFO. It lets NUM_REQ producers share the single write port (`dataIn`/`wr_clk` domain) of one FIFO. Bursts are granted atomically, so words from different producers never interleave inside a burst. The block sits in the write clock domain, directly in front of the FIFO's write side, and honours the FIFO's FULL flag as backpressure.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, `bitLength, word width
- MAX_BURST, 4, maximum words per grant (1..16)

Ports:
- Clk  in  1  write-side clock; drives the FIFO `wr_clk`
- Rst  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  NUM_REQ  requester i has a word on its data slice
- req_last  in  NUM_REQ  the word of requester i is the last of its burst
- req_data  in  NUM_REQ*DATA_W  slice i is [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot or zero; word i is consumed this cycle
- fifo_full  in  1  FULL flag from the FIFO
- fifo_wr_en  out  1  write strobe to the FIFO
- fifo_wr_data  out  DATA_W  write data to the FIFO
- owner  out  $clog2(NUM_REQ)  index of the current grant holder (valid when busy)
- busy  out  1  a burst is in progress (state GRANT)

## Operation
- FSM has two states: IDLE and GRANT. Registers: state, owner, last_owner, beat_cnt.
- IDLE: if any req_valid is set, select the first set bit scanning from last_owner+1 upward (mod NUM_REQ). Load owner, clear beat_cnt, go to GRANT. Otherwise stay in IDLE.
- GRANT:
  - accept = req_valid[owner] & ~fifo_full
  - req_ready[owner] = accept; all other bits are 0
  - fifo_wr_en = accept; fifo_wr_data = req_data slice[owner], combinational
  - On accept, beat_cnt increments.
  - Exit to IDLE and set last_owner = owner when any of these holds:
    - (a) accept & req_last[owner]
    - (b) accept & beat_cnt == MAX_BURST-1
    - (c) ~req_valid[owner], meaning the requester dropped out
  - fifo_full alone never ends a burst. The grant is held, with no timeout.
- In IDLE, req_ready = 0, fifo_wr_en = 0, fifo_wr_data = 0.
- beat_cnt is $clog2(MAX_BURST+1) bits wide and never wraps, because exit (b) occurs first.

## Timing
- Reset values: state = IDLE, owner = 0, last_owner = NUM_REQ-1 (so requester 0 wins first), beat_cnt = 0, busy = 0, req_ready = 0, fifo_wr_en = 0, fifo_wr_data = 0.
- Reset is asynchronous. Asserting it mid-burst forces IDLE immediately, and outputs drop in the same instant. A word presented in that cycle is not written.
- Arbitration latency: req_valid high in IDLE at edge N leads to GRANT after edge N. The first word can be accepted in cycle N+1.
- Each burst is followed by exactly one IDLE cycle, so back-to-back bursts have one bubble.
- Throughput is 1 word per cycle within a burst while fifo_full = 0.
- fifo_full is sampled combinationally in the same cycle as the write. When the FIFO drives FULL high, it must not be written that cycle.
- Simultaneous events:
  - req_last together with beat MAX_BURST-1 counts as one exit.
  - fifo_full high together with req_last means no accept and no exit; the last word waits.
  - A requester that deasserts req_valid while fifo_full is high still ends its burst under rule (c).

## Structure
- The shared package/header holds DATA_W from `bitLength, the state encoding (ST_IDLE = 1'b0, ST_GRANT = 1'b1), and the $clog2 width helper.
- Sub-module rr_pick: purely combinational round-robin priority picker.
  - Inputs: req vector and last index.
  - Outputs: found flag and index.
  - It is reused by later read-side schedulers.
- Top level holds the FSM, the counter, and the data mux.

## Test plan
- Reset, then req_valid = 4'b1111, all req_last = 1, fifo_full = 0 → owner sequence 0, 1, 2, 3, 0. One word per burst, each burst separated by one idle cycle.
- Requester 2 alone, 6 words, req_last on word 6, MAX_BURST = 4 → words 1–4 written on consecutive cycles, 1 bubble, regrant to 2, words 5–6 written, busy falls after word 6.
- fifo_full raised for 3 cycles after word 2 of a 4-word burst from requester 1 → no fifo_wr_en for 3 cycles. owner stays 1 and words 3–4 follow with no other requester interleaved, even while requester 0 is valid.
- Requester 3 drops req_valid after 2 words, with requesters 0 and 3 pending → burst ends, last_owner = 3, next grant goes to 0.
- Rst pulsed low during word 2 of a burst from requester 2 → fifo_wr_en = 0 immediately, busy = 0. After release, with all valid, the first grant goes to 0.
- Scoreboard across a random 1000-cycle run with random fifo_full → FIFO contents equal the per-requester input order, with no interleaving within any burst and no write while fifo_full = 1.
